// File: rtl/sgdmac_pkg.sv
// ============================================================================
// Module      : sgdmac_pkg
// Description : Shared definitions for the scatter-gather DMA write engine:
//               FSM state encoding, burst geometry and AXI field constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sgdmac_pkg;

    // Write engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WREQ  = 2'd1,
        ST_WDATA = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    // One full burst: 16 beats of 4 bytes
    localparam int         BURST_BYTES    = 64;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

`default_nettype wire

// File: rtl/sgdmac_write.sv
// ============================================================================
// Module      : sgdmac_write
// Description : DMA write engine. Takes a {dst address, byte length} command,
//               drains a show-ahead FIFO into AXI3 INCR bursts of up to 16
//               32-bit beats, one burst outstanding at a time.
//               A burst is only requested once all of its beats are buffered,
//               so the W phase never has to wait on an under-filled FIFO
//               beyond transient empty cycles.
// Ports       : clk/rst            - clock, async active-high reset
//               aw*/w*/b*          - AXI3 write master channels
//               start_i/cmd_i      - command strobe {addr[47:16], len[15:0]}
//               done_o/err_o       - idle flag, sticky BRESP error
//               fifo_*             - upstream show-ahead FIFO interface
// Options     : SGDMAC_WRITE_BRESP_CHK_EN - when defined, err_o latches a
//               SLVERR/DECERR response until the next accepted command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgdmac_write
    import sgdmac_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    // AW channel
    output logic [3:0]       awid_o,
    output logic [31:0]      awaddr_o,
    output logic [3:0]       awlen_o,
    output logic [2:0]       awsize_o,
    output logic [1:0]       awburst_o,
    output logic             awvalid_o,
    input  logic             awready_i,
    // W channel
    output logic [3:0]       wid_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       wstrb_o,
    output logic             wlast_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    // B channel
    input  logic [3:0]       bid_i,
    input  logic [1:0]       bresp_i,
    input  logic             bvalid_i,
    output logic             bready_o,
    // Command / status
    input  logic             start_i,
    input  logic [47:0]      cmd_i,
    output logic             done_o,
    output logic             err_o,
    // Upstream FIFO
    input  logic             fifo_empty_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    input  logic [31:0]      fifo_rdata_i,
    output logic             fifo_rden_o
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [15:0] r_cnt;
    logic [3:0]  r_len;
    logic [3:0]  r_beat;

    logic [3:0]  w_awlen;
    logic        w_fifo_ready;
    logic        w_start_ok;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_unused;

    // Constant AXI fields
    assign awid_o    = 4'd0;
    assign awsize_o  = AXI_SIZE_4B;
    assign awburst_o = AXI_BURST_INCR;
    assign wid_o     = 4'd0;
    assign wstrb_o   = 4'hF;

    // Burst length: a full 16-beat burst while 64+ bytes remain, otherwise
    // the remaining whole words. cnt[1:0] never contributes.
    assign w_awlen  = (r_cnt >= 16'(BURST_BYTES)) ? 4'hF : (r_cnt[5:2] - 4'd1);
    assign awaddr_o = r_addr;
    assign awlen_o  = w_awlen;

    // Compare at 32 bits so any FIFO_DEPTH width works against the 5-bit need
    assign w_fifo_ready = (32'(fifo_cnt_i) >= (32'(w_awlen) + 32'd1));

    assign wdata_o = fifo_rdata_i;
    assign done_o  = (r_state == ST_IDLE);

    assign w_start_ok = (r_state == ST_IDLE) && start_i && (cmd_i[15:0] != 16'd0);
    assign w_aw_hs    = awvalid_o && awready_i;
    assign w_w_hs     = wvalid_o && wready_i;
    assign w_b_hs     = bvalid_i && bready_o;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and channel handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        wlast_o     = 1'b0;
        bready_o    = 1'b0;
        fifo_rden_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_WREQ;
                end
            end
            ST_WREQ: begin
                // Nothing pops in this state, so occupancy cannot fall and
                // awvalid_o stays asserted until accepted.
                awvalid_o = w_fifo_ready;
                if (w_fifo_ready && awready_i) begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                wvalid_o    = !fifo_empty_i;
                wlast_o     = (r_beat == r_len);
                fifo_rden_o = !fifo_empty_i && wready_i;
                if (!fifo_empty_i && wready_i && (r_beat == r_len)) begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    w_state_nxt = (r_cnt == 16'd0) ? ST_IDLE : ST_WREQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / remaining-length / beat tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= 32'd0;
            r_cnt  <= 16'd0;
            r_len  <= 4'd0;
            r_beat <= 4'd0;
        end else begin
            if (w_start_ok) begin
                r_addr <= cmd_i[47:16];
                r_cnt  <= cmd_i[15:0];
            end
            if (w_aw_hs) begin
                r_len  <= w_awlen;
                r_beat <= 4'd0;
                r_addr <= r_addr + 32'(BURST_BYTES);
                r_cnt  <= (r_cnt < 16'(BURST_BYTES)) ? 16'd0 : (r_cnt - 16'(BURST_BYTES));
            end
            if (w_w_hs) begin
                r_beat <= r_beat + 4'd1;
            end
        end
    end

`ifdef SGDMAC_WRITE_BRESP_CHK_EN
    logic r_err;

    // Sticky error: an accepted command clears it, an error response sets it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_b_hs && bresp_i[1]) begin
            r_err <= 1'b1;
        end
    end

    assign err_o    = r_err;
    assign w_unused = &{1'b0, bid_i, bresp_i[0]};
`else
    assign err_o    = 1'b0;
    assign w_unused = &{1'b0, bid_i, bresp_i, w_b_hs};
`endif

endmodule

`default_nettype wire

// File: tb/tb_sgdmac_write.sv
// ============================================================================
// Module      : tb_sgdmac_write
// Description : Directed self-checking bench for sgdmac_write. A small
//               show-ahead FIFO model feeds the DUT; AXI responses are driven
//               from a single linear stimulus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgdmac_write;

    localparam int FIFO_DEPTH = 64;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef SGDMAC_WRITE_BRESP_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       awid_o;
    logic [31:0]      awaddr_o;
    logic [3:0]       awlen_o;
    logic [2:0]       awsize_o;
    logic [1:0]       awburst_o;
    logic             awvalid_o;
    logic             awready_i = 1'b0;
    logic [3:0]       wid_o;
    logic [31:0]      wdata_o;
    logic [3:0]       wstrb_o;
    logic             wlast_o;
    logic             wvalid_o;
    logic             wready_i = 1'b0;
    logic [3:0]       bid_i = 4'd0;
    logic [1:0]       bresp_i = 2'b00;
    logic             bvalid_i = 1'b0;
    logic             bready_o;
    logic             start_i = 1'b0;
    logic [47:0]      cmd_i = 48'd0;
    logic             done_o;
    logic             err_o;
    logic             fifo_empty_i;
    logic [CNT_W-1:0] fifo_cnt_i;
    logic [31:0]      fifo_rdata_i;
    logic             fifo_rden_o;

    // FIFO model: the initial block owns wr_ptr/mem, the always block owns rd_ptr
    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_count = 0;
    logic        force_empty = 1'b0;
    int          exp_idx = 0;

    int checks   = 0;
    int failures = 0;

    assign fifo_empty_i = ((wr_ptr - rd_ptr) == 0) || force_empty;
    assign fifo_cnt_i   = CNT_W'(wr_ptr - rd_ptr);
    assign fifo_rdata_i = mem[rd_ptr % 256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rden_o) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
    end

    sgdmac_write #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .awid_o       (awid_o),
        .awaddr_o     (awaddr_o),
        .awlen_o      (awlen_o),
        .awsize_o     (awsize_o),
        .awburst_o    (awburst_o),
        .awvalid_o    (awvalid_o),
        .awready_i    (awready_i),
        .wid_o        (wid_o),
        .wdata_o      (wdata_o),
        .wstrb_o      (wstrb_o),
        .wlast_o      (wlast_o),
        .wvalid_o     (wvalid_o),
        .wready_i     (wready_i),
        .bid_i        (bid_i),
        .bresp_i      (bresp_i),
        .bvalid_i     (bvalid_i),
        .bready_o     (bready_o),
        .start_i      (start_i),
        .cmd_i        (cmd_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_cnt_i   (fifo_cnt_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = base + 32'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len);
        @(negedge clk);
        start_i = 1'b1;
        cmd_i   = {addr, len};
        @(negedge clk);
        start_i = 1'b0;
        cmd_i   = 48'd0;
        #1;
    endtask

    // One AW/W/B burst. toggle=1 alternates wready and inserts FIFO-empty pulses.
    task automatic run_burst(input logic [31:0] exp_addr, input int exp_len,
                             input logic [1:0] resp, input bit toggle);
        int beats;
        for (int i = 0; i < 60 && !awvalid_o; i++) begin
            @(negedge clk);
            #1;
        end
        chk("aw_valid", {31'd0, awvalid_o}, 32'd1);
        chk("awaddr", awaddr_o, exp_addr);
        chk("awlen", {28'd0, awlen_o}, 32'(exp_len));
        chk("aw_phase_quiet", {29'd0, wvalid_o, fifo_rden_o, bready_o}, 32'd0);
        awready_i = 1'b1;
        @(negedge clk);
        awready_i = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 100 && beats <= exp_len; cyc++) begin
            wready_i    = toggle ? (cyc % 2 == 0) : 1'b1;
            force_empty = toggle && (cyc == 4 || cyc == 7);
            #1;
            chk("wvalid_vs_empty", {31'd0, wvalid_o}, {31'd0, !fifo_empty_i});
            if (wvalid_o && wready_i) begin
                chk("wdata", wdata_o, mem[exp_idx % 256]);
                chk("wlast", {31'd0, wlast_o}, {31'd0, beats == exp_len});
                chk("rden_on_hs", {31'd0, fifo_rden_o}, 32'd1);
                exp_idx++;
                beats++;
            end else begin
                chk("rden_no_hs", {31'd0, fifo_rden_o}, 32'd0);
            end
            @(negedge clk);
        end
        wready_i    = 1'b0;
        force_empty = 1'b0;
        #1;
        chk("w_beats", 32'(beats), 32'(exp_len + 1));
        chk("bready", {31'd0, bready_o}, 32'd1);
        chk("wvalid_in_resp", {31'd0, wvalid_o}, 32'd0);
        bvalid_i = 1'b1;
        bresp_i  = resp;
        @(negedge clk);
        bvalid_i = 1'b0;
        bresp_i  = 2'b00;
        #1;
    endtask

    initial begin
        int pops0;
        int beats;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", {31'd0, done_o}, 32'd1);
        chk("rst_valids", {28'd0, awvalid_o, wvalid_o, bready_o, fifo_rden_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("const_fields", {awid_o, awsize_o, awburst_o, wid_o, wstrb_o}, {13'd0, 4'd0, 3'b010, 2'b01, 4'd0, 4'hF});
        chk("idle_done", {31'd0, done_o}, 32'd1);

        // ---- zero-length start is ignored ----
        send_cmd(32'h1234_0000, 16'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("zero_len_done", {31'd0, done_o}, 32'd1);
        chk("zero_len_no_aw", {31'd0, awvalid_o}, 32'd0);

        // ---- single full burst ----
        push(16, 32'hA000_0000);
        send_cmd(32'h1000_0000, 16'd64);
        chk("busy_after_start", {31'd0, done_o}, 32'd0);
        run_burst(32'h1000_0000, 15, 2'b00, 1'b0);
        chk("done_after_b", {31'd0, done_o}, 32'd1);
        chk("err_okay", {31'd0, err_o}, 32'd0);

        // ---- 72 bytes: full burst then 2-beat tail ----
        push(18, 32'hB000_0000);
        send_cmd(32'h2000_0000, 16'd72);
        run_burst(32'h2000_0000, 15, 2'b00, 1'b0);
        chk("mid_cmd_busy", {31'd0, done_o}, 32'd0);
        run_burst(32'h2000_0040, 1, 2'b00, 1'b0);
        chk("done_after_72", {31'd0, done_o}, 32'd1);

        // ---- AW gated on full buffering; start ignored when busy ----
        push(10, 32'hC000_0000);
        send_cmd(32'h3000_0000, 16'd64);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("aw_wait_10", {31'd0, awvalid_o}, 32'd0);
        end
        send_cmd(32'h5000_0000, 16'd8);
        push(5, 32'hC000_000A);
        #1;
        chk("aw_wait_15", {31'd0, awvalid_o}, 32'd0);
        @(negedge clk);
        push(1, 32'hC000_000F);
        #1;
        chk("aw_go_16", {31'd0, awvalid_o}, 32'd1);
        chk("busy_start_ignored", awaddr_o, 32'h3000_0000);

        // ---- wready toggling and FIFO empty pulses ----
        pops0 = pop_count;
        run_burst(32'h3000_0000, 15, 2'b00, 1'b1);
        chk("pop_count", 32'(pop_count - pops0), 32'd16);
        chk("done_after_toggle", {31'd0, done_o}, 32'd1);

        // ---- error response ----
        push(4, 32'hD000_0000);
        send_cmd(32'h4000_0000, 16'd16);
        run_burst(32'h4000_0000, 3, 2'b10, 1'b0);
        chk("err_after_slverr", {31'd0, err_o}, {31'd0, EXP_ERR});
        chk("done_after_err", {31'd0, done_o}, 32'd1);

        // ---- reset mid-burst (beat 5), error cleared by new start ----
        push(16, 32'hE000_0000);
        send_cmd(32'h6000_0000, 16'd64);
        chk("err_cleared_by_start", {31'd0, err_o}, 32'd0);
        for (int i = 0; i < 60 && !awvalid_o; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_test_aw", {31'd0, awvalid_o}, 32'd1);
        awready_i = 1'b1;
        @(negedge clk);
        awready_i = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
            wready_i = 1'b1;
            #1;
            if (wvalid_o) beats++;
            @(negedge clk);
        end
        chk("pre_rst_beats", 32'(beats), 32'd4);
        #1;
        chk("beat5_wvalid", {31'd0, wvalid_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wvalid", {31'd0, wvalid_o}, 32'd0);
        chk("rst_done_mid", {31'd0, done_o}, 32'd1);
        chk("rst_rden", {31'd0, fifo_rden_o}, 32'd0);
        @(negedge clk);
        wready_i = 1'b0;
        rst      = 1'b0;
        wr_ptr   = rd_ptr;
        exp_idx  = rd_ptr;
        push(4, 32'hF000_0000);
        send_cmd(32'h7000_0000, 16'd16);
        run_burst(32'h7000_0000, 3, 2'b00, 1'b0);
        chk("post_rst_done", {31'd0, done_o}, 32'd1);
        chk("post_rst_err", {31'd0, err_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sgdmac_write.md
SGDMAC_WRITE -- requirements
Module: sgdmac_write

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, depth of the upstream data FIFO (sets fifo_cnt_i width).
REQ-002 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge
  rst  in  1  asynchronous, active-high reset
  awid_o  out  4  write ID, constant 0
  awaddr_o  out  32  burst start byte address
  awlen_o  out  4  beats-1 (AXI3)
  awsize_o  out  3  constant 3'b010 (4 bytes)
  awburst_o  out  2  constant 2'b01 (INCR)
  awvalid_o / awready_i  out/in  1  AW handshake
  wid_o  out  4  constant 0
  wdata_o  out  32  write data
  wstrb_o  out  4  constant 4'hF
  wlast_o  out  1  last beat of burst
  wvalid_o / wready_i  out/in  1  W handshake
  bid_i  in  4  ignored
  bresp_i  in  2  write response
  bvalid_i / bready_o  in/out  1  B handshake
  start_i  in  1  command strobe
  cmd_i  in  48  {dst address[47:16], byte length[15:0]}
  done_o  out  1  high when idle
  err_o  out  1  sticky write-response error
  fifo_empty_i  in  1  FIFO empty
  fifo_cnt_i  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy in words
  fifo_rdata_i  in  32  show-ahead FIFO head word
  fifo_rden_o  out  1  FIFO pop

Function
REQ-003 SHALL implement states IDLE, WREQ, WDATA, WRESP.
REQ-004 IDLE: done_o=1; on start_i with cmd_i[15:0]!=0, latch addr=cmd_i[47:16], cnt=cmd_i[15:0], go WREQ; start_i with length 0 ignored, no AXI traffic.
REQ-005 start_i outside IDLE SHALL be ignored.
REQ-006 Length is bytes, a multiple of 4 (caller's obligation); cnt[1:0] ignored.
REQ-007 awlen_o SHALL be 4'hF when cnt>=64, else cnt[5:2]-1; awaddr_o=addr.
REQ-008 WREQ: awvalid_o = (fifo_cnt_i >= awlen_o+1), so a burst issues only when fully buffered; once high it holds until awready_i (no pops occur in WREQ).
REQ-009 AW handshake: latch awlen into burst register, beat counter=0, addr+=64, cnt = (cnt<64)?0:cnt-64, go WDATA.
REQ-010 WDATA: wvalid_o=!fifo_empty_i, wdata_o=fifo_rdata_i, fifo_rden_o=wvalid_o&wready_i (same cycle, zero latency).
REQ-011 wlast_o=1 when beat counter equals latched awlen; counter increments per W handshake; W handshake with wlast_o goes WRESP.
REQ-012 WRESP: bready_o=1; on bvalid_i go IDLE if cnt==0, else WREQ.
REQ-013 Outside their states awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o SHALL be 0.
REQ-014 Only one burst outstanding; AW, W, B strictly sequential.
REQ-015 Address arithmetic is 32-bit modulo; 4KB crossing is caller's obligation (64B-aligned addr).

Reset
REQ-016 rst SHALL force IDLE, addr=0, cnt=0, beat counter=0, err=0 immediately, including mid-burst; outputs: done_o=1, all valid/ready/rden/err_o=0.

Configuration
REQ-017 Macro SGDMAC_WRITE_BRESP_CHK_EN defined: err_o set when bvalid_i&bready_o&bresp_i[1], held until next accepted start_i; transfer still completes. Undefined: err_o tied 0, bresp_i ignored.

Structure
REQ-018 Shared package sgdmac_pkg SHALL hold the state enum, BURST_BYTES=64, AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01.
REQ-019 Single flat module; no sub-module.

Verification
REQ-020 cmd {0x1000_0000,64}, FIFO holds 16 words -> one AW awaddr 0x1000_0000 awlen 15, 16 beats, wlast on beat 16, done_o after B.
REQ-021 cmd {0x2000_0000,72} -> bursts awlen 15 @0x2000_0000, awlen 1 @0x2000_0040, then IDLE.
REQ-022 cmd length 64, fifo_cnt_i=10 -> awvalid_o stays 0 until fifo_cnt_i reaches 16.
REQ-023 wready_i toggled 1/0 and fifo_empty_i pulses mid-burst -> fifo_rden_o only on wvalid&wready, 16 pops exactly, data order preserved.
REQ-024 macro on, bresp=2'b10 -> err_o=1 after B, cleared by next start_i; macro off -> err_o=0.
REQ-025 rst asserted during beat 5 of WDATA -> same-cycle wvalid_o=0, done_o=1; new cmd after release runs cleanly.
